seg7_display_ctrl: RTL

Parametrised N-digit seven-segment display controller, the successor to the fixed per-digit hex decoder peripherals in the Nios system. It is an Avalon-MM slave that takes a 32-bit value from software and drives NUM_DIGITS active-low seven-segment conduits. It adds hex or decimal display (sequential binary-to-BCD), leading-zero blanking, a per-digit enable mask, overflow indication and blinking.

---
 rtl/seg7_display_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/seg7_display_ctrl.sv
// seg7_display_ctrl: Avalon-MM slave driving NUM_DIGITS active-low seven-segment
// digits from a 32-bit value. Hex or decimal (sequential double-dabble) display,
// leading-zero blanking, per-digit enable, overflow dashes and blinking.
module seg7_display_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int BLINK_DIV  = 25_000_000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              avs_address,
  input  logic                    avs_write,
  input  logic [31:0]             avs_writedata,
  input  logic                    avs_read,
  output logic [31:0]             avs_readdata,
  output logic [7*NUM_DIGITS-1:0] hex_out,
  output logic                    busy
);
  localparam int DW = 4*NUM_DIGITS;   // digit register width
  localparam int BW = DW + 4;         // BCD shifter, one spare nibble to catch overflow
  localparam int CW = $clog2(BLINK_DIV);

  typedef enum logic [1:0] {IDLE, HEX, CONV, LOAD} state_t;

  state_t            state, state_n;
  logic [31:0]       value;
  logic              mode, lzb, blink;
  logic [7:0]        mask;
  logic [31:0]       sh, sh_n;
  logic [BW-1:0]     bcd, bcd_n, adj;
  logic              conv_ovf, conv_ovf_n;
  logic [4:0]        cnt, cnt_n;
  logic [DW-1:0]     digits, dig_n;
  logic              ovf, ovf_n;
  logic [NUM_DIGITS-1:0] d_mask, d_mask_n;
  logic              d_lzb, d_lzb_n, d_blink, d_blink_n;
  logic [CW-1:0]     bcnt, bcnt_n;
  logic              phase, phase_n;
  logic [7*NUM_DIGITS-1:0] seg_n;
  logic              hz;
  logic [3:0]        dv;

  logic        wr_value, wr_ctrl, start, new_mode, hex_ovf;
  logic [31:0] new_value;
  logic        unused_bits;

  assign wr_value  = avs_write && (avs_address == 2'd0);
  assign wr_ctrl   = avs_write && (avs_address == 2'd1);
  assign start     = wr_value || wr_ctrl;
  assign new_value = wr_value ? avs_writedata : value;
  assign new_mode  = wr_ctrl ? avs_writedata[0] : mode;
  // Value does not fit in NUM_DIGITS hex digits; never true for 8 digits.
  assign hex_ovf   = (({32'd0, value}) >> DW) != 64'd0;
  assign unused_bits = ^{avs_writedata[31:16], avs_writedata[7:3], adj[BW-1]};

  function automatic logic [6:0] glyph(input logic [3:0] v);
    case (v)
      4'h0: glyph = 7'h40;  4'h1: glyph = 7'h79;  4'h2: glyph = 7'h24;  4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;  4'h5: glyph = 7'h12;  4'h6: glyph = 7'h02;  4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;  4'h9: glyph = 7'h10;  4'hA: glyph = 7'h08;  4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;  4'hD: glyph = 7'h21;  4'hE: glyph = 7'h06;  default: glyph = 7'h0E;
    endcase
  endfunction

  // Software-visible registers
  always_ff @(posedge clk) begin
    if (reset) begin
      value <= '0;
      mode  <= 1'b0;
      lzb   <= 1'b0;
      blink <= 1'b0;
      mask  <= 8'hFF;
    end else begin
      if (wr_value) value <= avs_writedata;
      if (wr_ctrl) begin
        mode  <= avs_writedata[0];
        lzb   <= avs_writedata[1];
        blink <= avs_writedata[2];
        mask  <= avs_writedata[15:8];
      end
    end
  end

  // Registered read port; returns contents from before any same-cycle write
  always_ff @(posedge clk) begin
    if (reset) avs_readdata <= '0;
    else if (avs_read) begin
      case (avs_address)
        2'd0:    avs_readdata <= value;
        2'd1:    avs_readdata <= {16'd0, mask, 5'd0, blink, lzb, mode};
        2'd2:    avs_readdata <= {30'd0, ovf, busy};
        default: avs_readdata <= '0;
      endcase
    end else avs_readdata <= '0;
  end

  // Update FSM next state plus conversion datapath; any write restarts the update
  always_comb begin
    state_n    = state;
    sh_n       = sh;
    bcd_n      = bcd;
    conv_ovf_n = conv_ovf;
    cnt_n      = cnt;
    dig_n      = digits;
    ovf_n      = ovf;
    d_mask_n   = d_mask;
    d_lzb_n    = d_lzb;
    d_blink_n  = d_blink;
    adj        = bcd;
    if (start) begin
      state_n    = new_mode ? CONV : HEX;
      sh_n       = new_value;
      bcd_n      = '0;
      conv_ovf_n = 1'b0;
      cnt_n      = '0;
    end else begin
      case (state)
        HEX: begin
          dig_n     = value[DW-1:0];
          ovf_n     = hex_ovf;
          d_mask_n  = mask[NUM_DIGITS-1:0];
          d_lzb_n   = lzb;
          d_blink_n = blink;
          state_n   = IDLE;
        end
        CONV: begin
          for (int i = 0; i < NUM_DIGITS; i++)
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
          bcd_n      = {adj[BW-2:0], sh[31]};
          sh_n       = {sh[30:0], 1'b0};
          // Digit values only grow, so any carry into the spare nibble is sticky.
          conv_ovf_n = conv_ovf || (bcd_n[BW-1 -: 4] != 4'd0);
          cnt_n      = cnt + 5'd1;
          if (cnt == 5'd31) state_n = LOAD;
        end
        LOAD: begin
          dig_n     = bcd[DW-1:0];
          ovf_n     = conv_ovf;
          d_mask_n  = mask[NUM_DIGITS-1:0];
          d_lzb_n   = lzb;
          d_blink_n = blink;
          state_n   = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // Free-running blink divider
  always_comb begin
    bcnt_n  = bcnt + CW'(1);
    phase_n = phase;
    if (bcnt == CW'(BLINK_DIV-1)) begin
      bcnt_n  = '0;
      phase_n = ~phase;
    end
  end

  // Segment rendering from next-cycle display state so hex_out stays a flop
  always_comb begin
    seg_n = '0;
    hz    = 1'b1;
    dv    = '0;
    for (int d = NUM_DIGITS-1; d >= 0; d--) begin
      dv = dig_n[4*d +: 4];
      if (!d_mask_n[d])                               seg_n[7*d +: 7] = 7'h7F;
      else if (d_blink_n && phase_n)                  seg_n[7*d +: 7] = 7'h7F;
      else if (ovf_n)                                 seg_n[7*d +: 7] = 7'h3F;
      else if (d_lzb_n && dv == 4'd0 && hz && d != 0) seg_n[7*d +: 7] = 7'h7F;
      else                                            seg_n[7*d +: 7] = glyph(dv);
      hz = hz && (dv == 4'd0);
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      sh       <= '0;
      bcd      <= '0;
      conv_ovf <= 1'b0;
      cnt      <= '0;
      digits   <= '0;
      ovf      <= 1'b0;
      d_mask   <= '1;
      d_lzb    <= 1'b0;
      d_blink  <= 1'b0;
      bcnt     <= '0;
      phase    <= 1'b0;
      busy     <= 1'b0;
      hex_out  <= {NUM_DIGITS{7'h40}};
    end else begin
      state    <= state_n;
      sh       <= sh_n;
      bcd      <= bcd_n;
      conv_ovf <= conv_ovf_n;
      cnt      <= cnt_n;
      digits   <= dig_n;
      ovf      <= ovf_n;
      d_mask   <= d_mask_n;
      d_lzb    <= d_lzb_n;
      d_blink  <= d_blink_n;
      bcnt     <= bcnt_n;
      phase    <= phase_n;
      busy     <= (state_n != IDLE);
      hex_out  <= seg_n;
    end
  end
endmodule
